// File: rtl/ptw_walk_ctrl.sv
// ptw_walk_ctrl: Sv39 page-table-walk controller arbitrating I-TLB/D-TLB misses
module ptw_walk_ctrl #(
  parameter int VIRTUAL_ADDR_LEN_SV39 = 39,
  parameter int PHYSICAL_ADDR_LEN_SV39 = 56,
  parameter int PTE_SIZE_IN_BIT = 64,
  parameter int SATP_PPN_WIDTH = 44,
  parameter int VPN_SLICE_WIDTH = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SATP_PPN_WIDTH-1:0]         satp_ppn_i,
  input  logic                              flush_i,
  input  logic                              itlb_req_valid_i,
  input  logic [VIRTUAL_ADDR_LEN_SV39-1:0]  itlb_req_vaddr_i,
  output logic                              itlb_req_ready_o,
  input  logic                              dtlb_req_valid_i,
  input  logic [VIRTUAL_ADDR_LEN_SV39-1:0]  dtlb_req_vaddr_i,
  output logic                              dtlb_req_ready_o,
  output logic                              mem_req_valid_o,
  output logic [PHYSICAL_ADDR_LEN_SV39-1:0] mem_req_addr_o,
  input  logic                              mem_req_ready_i,
  input  logic                              mem_resp_valid_i,
  input  logic [PTE_SIZE_IN_BIT-1:0]        mem_resp_data_i,
  input  logic                              mem_resp_err_i,
  output logic                              walk_resp_valid_o,
  output logic                              walk_resp_id_o,
  output logic [PTE_SIZE_IN_BIT-1:0]        walk_resp_pte_o,
  output logic [1:0]                        walk_resp_level_o,
  output logic                              walk_resp_page_fault_o,
  input  logic                              walk_resp_ready_i,
  output logic                              busy_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;
  state_t r_state, w_next;
  logic r_rr, r_id, r_fault;
  logic [1:0] r_level;
  logic [VIRTUAL_ADDR_LEN_SV39-1:0] r_vaddr;
  logic [SATP_PPN_WIDTH-1:0] r_base;
  logic [PTE_SIZE_IN_BIT-1:0] r_pte;
  logic w_idle, w_gnt_i, w_gnt_d, w_leaf, w_mis, w_fault, w_down, w_unused;
  logic [VPN_SLICE_WIDTH-1:0] w_vpn;
  logic [SATP_PPN_WIDTH-1:0] w_ppn;
  assign w_idle = r_state == IDLE && !flush_i && !rst;
  assign w_gnt_d = w_idle && dtlb_req_valid_i && (!itlb_req_valid_i || r_rr);
  assign w_gnt_i = w_idle && itlb_req_valid_i && (!dtlb_req_valid_i || !r_rr);
  assign w_ppn = mem_resp_data_i[53:10];
  assign w_leaf = mem_resp_data_i[1] || mem_resp_data_i[3];
  assign w_mis = (r_level == 2'd1 && w_ppn[8:0] != '0) || (r_level == 2'd2 && w_ppn[17:0] != '0);
  assign w_fault = mem_resp_err_i || !mem_resp_data_i[0] || (!mem_resp_data_i[1] && mem_resp_data_i[2]) ||
                   (w_leaf ? w_mis : r_level == 2'd0);
  assign w_down = !w_fault && !w_leaf;
  assign w_vpn = r_level == 2'd2 ? r_vaddr[38:30] : r_level == 2'd1 ? r_vaddr[29:21] : r_vaddr[20:12];
  assign w_unused = ^{mem_resp_data_i[63:54], mem_resp_data_i[9:4], r_vaddr[11:0]};
  assign itlb_req_ready_o = w_gnt_i;
  assign dtlb_req_ready_o = w_gnt_d;
  assign mem_req_valid_o = r_state == REQ;
  assign mem_req_addr_o = mem_req_valid_o ? {r_base, w_vpn, 3'b000} : '0;
  assign walk_resp_valid_o = r_state == RESP;
  assign walk_resp_id_o = walk_resp_valid_o && r_id;
  assign walk_resp_pte_o = walk_resp_valid_o ? r_pte : '0;
  assign walk_resp_level_o = walk_resp_valid_o ? r_level : 2'd0;
  assign walk_resp_page_fault_o = walk_resp_valid_o && r_fault;
  assign busy_o = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_gnt_i || w_gnt_d ? REQ : IDLE;
      REQ:   w_next = flush_i ? (mem_req_ready_i ? DRAIN : IDLE) : mem_req_ready_i ? WAIT : REQ;
      WAIT:  w_next = flush_i ? (mem_resp_valid_i ? IDLE : DRAIN) : !mem_resp_valid_i ? WAIT : w_down ? REQ : RESP;
      RESP:  w_next = flush_i || walk_resp_ready_i ? IDLE : RESP;
      DRAIN: w_next = mem_resp_valid_i ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= 1'b1;
      r_id <= 1'b0;
      r_level <= 2'd2;
      r_vaddr <= '0;
      r_base <= '0;
      r_pte <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_i || w_gnt_d) begin
        r_vaddr <= w_gnt_d ? dtlb_req_vaddr_i : itlb_req_vaddr_i;
        r_id <= w_gnt_d;
        r_level <= 2'd2;
        r_base <= satp_ppn_i;
        if (itlb_req_valid_i && dtlb_req_valid_i) r_rr <= !r_rr;
      end
      if (r_state == WAIT && mem_resp_valid_i && !flush_i) begin
        if (w_down) begin
          r_base <= w_ppn;
          r_level <= r_level - 2'd1;
        end else begin
          r_pte <= w_fault ? '0 : mem_resp_data_i;
          r_fault <= w_fault;
        end
      end
    end
  end
endmodule

// File: tb/tb_ptw_walk_ctrl.sv
// tb_ptw_walk_ctrl: randomized walk-level checking of ptw_walk_ctrl against a behavioural model
module tb_ptw_walk_ctrl;
  logic clk = 0, rst = 1;
  logic [43:0] satp_ppn_i = '0;
  logic flush_i = 0;
  logic itlb_req_valid_i = 0, dtlb_req_valid_i = 0;
  logic [38:0] itlb_req_vaddr_i = '0, dtlb_req_vaddr_i = '0;
  logic itlb_req_ready_o, dtlb_req_ready_o;
  logic mem_req_valid_o;
  logic [55:0] mem_req_addr_o;
  logic mem_req_ready_i = 0, mem_resp_valid_i = 0, mem_resp_err_i = 0;
  logic [63:0] mem_resp_data_i = '0;
  logic walk_resp_valid_o, walk_resp_id_o, walk_resp_page_fault_o, busy_o;
  logic [63:0] walk_resp_pte_o;
  logic [1:0] walk_resp_level_o;
  logic walk_resp_ready_i = 0;
  int n_vec = 0, n_err = 0;
  bit m_rr = 1;
  logic [63:0] pt[3];
  bit pe[3];
  ptw_walk_ctrl dut (
    .clk(clk), .rst(rst), .satp_ppn_i(satp_ppn_i), .flush_i(flush_i),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_vaddr_i(itlb_req_vaddr_i), .itlb_req_ready_o(itlb_req_ready_o),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_vaddr_i(dtlb_req_vaddr_i), .dtlb_req_ready_o(dtlb_req_ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
    .walk_resp_valid_o(walk_resp_valid_o), .walk_resp_id_o(walk_resp_id_o), .walk_resp_pte_o(walk_resp_pte_o),
    .walk_resp_level_o(walk_resp_level_o), .walk_resp_page_fault_o(walk_resp_page_fault_o),
    .walk_resp_ready_i(walk_resp_ready_i), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int classify(input logic [63:0] p, input bit e, input int lvl);
    logic [43:0] ppn;
    ppn = p[53:10];
    if (e || !p[0] || (!p[1] && p[2])) return 2;
    if (p[1] || p[3]) return (lvl > 0 && ppn % (44'd1 << (9 * lvl)) != 0) ? 2 : 1;
    return lvl == 0 ? 2 : 0;
  endfunction
  function automatic logic [55:0] pte_addr(input logic [43:0] base, input logic [38:0] va, input int lvl);
    logic [55:0] vpn;
    vpn = 56'((va >> (12 + 9 * lvl)) % 512);
    return {12'd0, base} * 56'd4096 + vpn * 56'd8;
  endfunction
  function automatic logic [63:0] gen_pte(input int lvl);
    logic [43:0] ppn;
    logic [3:0] f;
    logic [19:0] lf;
    int k;
    lf = 20'hFB973;
    ppn = 44'({$urandom, $urandom});
    k = $urandom_range(0, 11);
    if (k < 6) f = 4'h1;
    else if (k < 10) begin
      f = lf[4 * $urandom_range(0, 4) +: 4];
      if (k < 9) ppn = ppn & ~((44'd1 << (9 * lvl)) - 44'd1);
    end else if (k == 10) f = {3'($urandom_range(0, 7)), 1'b0};
    else f = {1'($urandom_range(0, 1)), 3'b101};
    return {10'($urandom), ppn, 6'($urandom), f};
  endfunction
  task automatic grant(input bit vi, input bit vd, input logic [38:0] ai, input logic [38:0] ad,
                       input logic [43:0] sp, output bit id);
    itlb_req_valid_i = vi;
    dtlb_req_valid_i = vd;
    itlb_req_vaddr_i = ai;
    dtlb_req_vaddr_i = ad;
    satp_ppn_i = sp;
    id = (vi && vd) ? m_rr : vd;
    #1;
    chk("grant_i_ready", itlb_req_ready_o, vi && !id);
    chk("grant_d_ready", dtlb_req_ready_o, vd && id);
    if (vi && vd) m_rr = !m_rr;
    @(negedge clk);
    itlb_req_valid_i = 0;
    dtlb_req_valid_i = 0;
    satp_ppn_i = 44'({$urandom, $urandom});
  endtask
  task automatic hs();
    mem_req_ready_i = 1;
    @(negedge clk);
    mem_req_ready_i = 0;
  endtask
  task automatic walk(input bit id, input logic [38:0] va, input logic [43:0] sp, input bit rnd, input int hold);
    logic [43:0] base;
    logic [55:0] ea;
    logic [63:0] exp_pte;
    int lvl, cls, d;
    base = sp;
    lvl = 2;
    cls = 0;
    for (int k = 0; k < 3; k++) begin
      ea = pte_addr(base, va, lvl);
      d = rnd ? $urandom_range(0, 2) : 0;
      repeat (d) begin
        chk("req_hold_valid", mem_req_valid_o, 1);
        chk("req_hold_addr", mem_req_addr_o, ea);
        @(negedge clk);
      end
      mem_req_ready_i = 1;
      chk("req_valid", mem_req_valid_o, 1);
      chk("req_addr", mem_req_addr_o, ea);
      @(negedge clk);
      mem_req_ready_i = 0;
      chk("wait_no_req", mem_req_valid_o, 0);
      d = rnd ? $urandom_range(0, 2) : 0;
      repeat (d) @(negedge clk);
      mem_resp_valid_i = 1;
      mem_resp_data_i = pt[lvl];
      mem_resp_err_i = pe[lvl];
      @(negedge clk);
      mem_resp_valid_i = 0;
      mem_resp_err_i = 0;
      mem_resp_data_i = {$urandom, $urandom};
      cls = classify(pt[lvl], pe[lvl], lvl);
      if (cls != 0) break;
      base = pt[lvl][53:10];
      lvl--;
    end
    exp_pte = cls == 2 ? 64'd0 : pt[lvl];
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", walk_resp_valid_o, 1);
      chk("resp_id", walk_resp_id_o, id);
      chk("resp_pte", walk_resp_pte_o, exp_pte);
      chk("resp_level", walk_resp_level_o, lvl);
      chk("resp_fault", walk_resp_page_fault_o, cls == 2);
      chk("resp_no_req", mem_req_valid_o, 0);
      if (h < hold) begin
        itlb_req_valid_i = 1'($urandom);
        dtlb_req_valid_i = 1'($urandom);
        #1;
        chk("resp_i_ready", itlb_req_ready_o, 0);
        chk("resp_d_ready", dtlb_req_ready_o, 0);
        @(negedge clk);
      end
    end
    itlb_req_valid_i = 0;
    dtlb_req_valid_i = 0;
    walk_resp_ready_i = 1;
    @(negedge clk);
    walk_resp_ready_i = 0;
    chk("done_valid", walk_resp_valid_o, 0);
    chk("done_busy", busy_o, 0);
  endtask
  task automatic load_t1();
    pt[2] = 64'h20000401;
    pt[1] = 64'h20000801;
    pt[0] = 64'h048D1403;
    pe = '{0, 0, 0};
  endtask
  initial begin
    bit id, vi, vd;
    logic [38:0] va, vb;
    logic [43:0] sp;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_req_valid", mem_req_valid_o, 0);
    chk("rst_req_addr", mem_req_addr_o, 0);
    chk("rst_resp_valid", walk_resp_valid_o, 0);
    chk("rst_resp_level", walk_resp_level_o, 0);
    rst = 0;
    @(negedge clk);
    load_t1();
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 0);
    pt[2] = 64'h0;
    for (int t = 0; t < 3; t++) begin
      va = 39'($urandom);
      vb = 39'($urandom);
      grant(1, 1, va, vb, 44'h12345, id);
      walk(id, id ? vb : va, 44'h12345, 0, 0);
    end
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 0);
    pt[2] = 64'h20000401;
    pt[1] = (64'h80001 << 10) | 64'h3;
    grant(1, 0, 39'h0040201000, '0, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 0);
    pt[1] = (64'h80200 << 10) | 64'h3;
    grant(1, 0, 39'h0040201000, '0, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 0);
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    hs();
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    repeat (3) begin
      chk("drain_busy", busy_o, 1);
      chk("drain_no_resp", walk_resp_valid_o, 0);
      chk("drain_no_req", mem_req_valid_o, 0);
      @(negedge clk);
    end
    mem_resp_valid_i = 1;
    @(negedge clk);
    mem_resp_valid_i = 0;
    chk("drain_idle", busy_o, 0);
    chk("drain_no_resp_end", walk_resp_valid_o, 0);
    load_t1();
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 0);
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    flush_i = 1;
    chk("flush_req_valid", mem_req_valid_o, 1);
    @(negedge clk);
    flush_i = 0;
    chk("flush_req_idle", busy_o, 0);
    chk("flush_req_no_req", mem_req_valid_o, 0);
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    hs();
    mem_resp_valid_i = 1;
    mem_resp_data_i = 64'h20000401;
    flush_i = 1;
    @(negedge clk);
    mem_resp_valid_i = 0;
    flush_i = 0;
    chk("flush_wait_idle", busy_o, 0);
    chk("flush_wait_no_req", mem_req_valid_o, 0);
    grant(1, 0, 39'h0040201000, '0, 44'h80000, id);
    hs();
    mem_resp_valid_i = 1;
    mem_resp_data_i = 64'h0;
    @(negedge clk);
    mem_resp_valid_i = 0;
    chk("flush_resp_pre", walk_resp_valid_o, 1);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    chk("flush_resp_drop", walk_resp_valid_o, 0);
    chk("flush_resp_idle", busy_o, 0);
    dtlb_req_valid_i = 1;
    flush_i = 1;
    #1;
    chk("flush_gnt_ready", dtlb_req_ready_o, 0);
    @(negedge clk);
    dtlb_req_valid_i = 0;
    flush_i = 0;
    chk("flush_gnt_idle", busy_o, 0);
    load_t1();
    grant(0, 1, '0, 39'h0040201000, 44'h80000, id);
    walk(id, 39'h0040201000, 44'h80000, 0, 5);
    grant(1, 0, 39'h0040201000, '0, 44'h80000, id);
    hs();
    rst = 1;
    @(negedge clk);
    chk("rstw_busy", busy_o, 0);
    chk("rstw_req_valid", mem_req_valid_o, 0);
    chk("rstw_req_addr", mem_req_addr_o, 0);
    chk("rstw_resp_valid", walk_resp_valid_o, 0);
    chk("rstw_resp_pte", walk_resp_pte_o, 0);
    chk("rstw_i_ready", itlb_req_ready_o, 0);
    rst = 0;
    m_rr = 1;
    @(negedge clk);
    repeat (80) begin
      vi = 1'($urandom_range(0, 1));
      vd = vi ? 1'($urandom_range(0, 1)) : 1'b1;
      va = 39'({$urandom, $urandom});
      vb = 39'({$urandom, $urandom});
      sp = 44'({$urandom, $urandom});
      for (int l = 0; l < 3; l++) begin
        pt[l] = gen_pte(l);
        pe[l] = $urandom_range(0, 11) == 0;
      end
      grant(vi, vd, va, vb, sp, id);
      walk(id, id ? vb : va, sp, 1, $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ptw_walk_ctrl.md
Name: ptw_walk_ctrl

Overview:
Sequential Sv39 page-table-walk controller serving I-TLB and D-TLB misses.
- Arbitrates between the two miss requesters and sequences the walk from level 2 down to level 0.
- Issues one PTE fetch per level to the memory port, classifies each returned PTE, and returns the leaf PTE or a page fault to the requesting TLB.
- Sits between the TLBs and the D-cache/memory request arbiter inside the MMU.

Parameters:
VIRTUAL_ADDR_LEN_SV39, 39, virtual address width
PHYSICAL_ADDR_LEN_SV39, 56, physical address width
PTE_SIZE_IN_BIT, 64, PTE width
SATP_PPN_WIDTH, 44, satp/PTE PPN width
VPN_SLICE_WIDTH, 9, VPN slice width per level

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
satp_ppn_i  input  44  root page-table PPN
flush_i  input  1  sfence.vma flush, aborts the walk in progress
itlb_req_valid_i  input  1  I-TLB miss request
itlb_req_vaddr_i  input  39  I-TLB miss address
itlb_req_ready_o  output  1  I-TLB request accepted this cycle
dtlb_req_valid_i  input  1  D-TLB miss request
dtlb_req_vaddr_i  input  39  D-TLB miss address
dtlb_req_ready_o  output  1  D-TLB request accepted this cycle
mem_req_valid_o  output  1  PTE fetch request
mem_req_addr_o  output  56  PTE physical address
mem_req_ready_i  input  1  memory accepted the fetch
mem_resp_valid_i  input  1  PTE data valid
mem_resp_data_i  input  64  PTE data
mem_resp_err_i  input  1  access error on the fetch
walk_resp_valid_o  output  1  walk result valid
walk_resp_id_o  output  1  result owner: 0 = I-TLB, 1 = D-TLB
walk_resp_pte_o  output  64  leaf PTE; 0 on fault
walk_resp_level_o  output  2  level at which the walk terminated
walk_resp_page_fault_o  output  1  walk ended in a fault
walk_resp_ready_i  input  1  owner consumed the result
busy_o  output  1  controller state is not IDLE

Behaviour:
Reset and general rules
- Reset: state IDLE; all outputs 0; rr_ptr = 1 (D-TLB wins the first tie); level = 2.
- One walk at a time. No requests are accepted outside IDLE.

States
- IDLE:
  - Grant exactly one valid requester, combinationally: req_ready_o = 1 for the winner only.
  - Both valid: grant the side selected by rr_ptr, then set rr_ptr to the other side.
  - Single requester: grant it; rr_ptr is unchanged.
  - On grant: latch vaddr and id, set level = 2, set base = satp_ppn_i, go to REQ.
- REQ:
  - mem_req_valid_o = 1; mem_req_addr_o = {base, vpn[level], 3'b000}.
  - vpn[2] = vaddr[38:30], vpn[1] = vaddr[29:21], vpn[0] = vaddr[20:12].
  - Address and valid stay stable until mem_req_ready_i. On handshake, go to WAIT.
- WAIT: on mem_resp_valid_i, classify the PTE using V = bit 0, R = bit 1, W = bit 2, X = bit 3, PPN = bits [53:10].
  - mem_resp_err_i → fault.
  - V = 0 → fault.
  - R = 0 and W = 1 → fault.
  - R = 1 or X = 1 (leaf): at level 1, PPN[8:0] != 0 → fault (misaligned superpage); at level 2, PPN[17:0] != 0 → fault; otherwise success with the PTE.
  - R = W = X = 0 (pointer): at level 0 → fault; otherwise base = PPN, level = level - 1, go to REQ.
  - Fault or success: load the response registers, go to RESP.
- RESP:
  - walk_resp_valid_o held with all fields stable until walk_resp_ready_i.
  - On handshake, go to IDLE. The earliest next grant is the following cycle.
- DRAIN:
  - Entered on flush_i while in WAIT, or in REQ after the handshake cycle.
  - Waits for mem_resp_valid_i, discards the data, goes to IDLE. No response is produced.

Flush
- IDLE: no effect.
- REQ before the handshake: abandon the fetch, go to IDLE.
- REQ on the handshake cycle: go to DRAIN.
- WAIT, same cycle as mem_resp_valid_i: discard the response, go to IDLE.
- RESP: drop the response, go to IDLE.
- Flush overrides any grant in the same cycle.

Other rules
- satp_ppn_i is sampled only at grant.
- A fault result reports the level being processed when the fault occurred.
- Latency with zero-wait memory: grant→REQ 1 cycle; 2 cycles per level (REQ, WAIT); a 3-level walk reaches RESP 7 cycles after grant.
- Address arithmetic is pure concatenation, 44 + 9 + 3 = 56 bits; no adder, no overflow.
- rst mid-walk returns to IDLE immediately. Any outstanding memory response is ignored by the memory side's own reset.

Test Plan:
1. Three-level walk. satp_ppn = 0x80000, D-TLB vaddr = 0x0040201000.
   - Fetch addresses 0x80000008, 0x80001008, 0x80002008.
   - Returned PTEs 0x20000401, 0x20000801, 0x048D1403.
   - Expect resp id = 1, pte = 0x048D1403, level = 0, fault = 0.
2. Simultaneous I-TLB and D-TLB requests after reset.
   - D-TLB is granted first, I-TLB on the next IDLE.
   - A third tie grants D-TLB again (alternation).
3. Level-2 PTE = 0x0 (V = 0) → response fault = 1, level = 2, pte = 0; exactly one memory request issued.
4. Level-1 leaf PTE = (0x80001 << 10) | 0x3 → misaligned superpage: fault = 1, level = 1. Level-1 leaf with PPN 0x80200 → success, level = 1.
5. flush_i one cycle after the REQ handshake.
   - Controller enters DRAIN and no walk_resp_valid_o is raised.
   - It returns to IDLE only after mem_resp_valid_i, then accepts a new request.
6. Hold walk_resp_ready_i = 0 for 5 cycles → walk_resp_valid_o and all fields stable, both req_ready_o = 0. rst asserted in WAIT → all outputs 0 the next cycle.
